// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M divide/remainder unit: op encodings and op decode helpers.
package div_unit_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    function automatic logic is_signed_op(input logic [1:0] op);
        return !op[0];
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Combinational two's-complement helper: passes value through, or negates it when neg is set.
module div_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional macro DIV_FASTPATH_EN resolves x/0, signed overflow and |a|<|b| in one cycle.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  div_start,
    input  logic [1:0]            div_op,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  flush,
    output logic                  div_busy,
    output logic                  div_valid,
    output logic [DATA_WIDTH-1:0] div_result
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

    state_t                state;
    logic [1:0]            op_q;
    logic                  q_neg;
    logic                  r_neg;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] div_b;
    logic [CW-1:0]         cnt;
    logic                  valid_q;

    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-1:0] abs_a;
    logic [DATA_WIDTH-1:0] abs_b;
    logic [DATA_WIDTH-1:0] quo_fixed;
    logic [DATA_WIDTH-1:0] rem_fixed;

    assign a_neg = is_signed_op(div_op) & dividend[DATA_WIDTH-1];
    assign b_neg = is_signed_op(div_op) & divisor[DATA_WIDTH-1];

    div_sign_fix #(.W(DATA_WIDTH)) u_abs_a (.value(dividend), .neg(a_neg), .result(abs_a));
    div_sign_fix #(.W(DATA_WIDTH)) u_abs_b (.value(divisor),  .neg(b_neg), .result(abs_b));
    div_sign_fix #(.W(DATA_WIDTH)) u_fix_q (.value(quo),      .neg(q_neg), .result(quo_fixed));
    div_sign_fix #(.W(DATA_WIDTH)) u_fix_r (.value(rem),      .neg(r_neg), .result(rem_fixed));

    // One restoring step; the extra top bit keeps the shifted remainder from overflowing.
    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH:0]   diff;
    logic                  take;
    logic [DATA_WIDTH-1:0] rem_next;
    logic [DATA_WIDTH-1:0] quo_next;

    assign rem_shift = {rem, quo[DATA_WIDTH-1]};
    assign diff      = rem_shift - {1'b0, div_b};
    assign take      = rem_shift >= {1'b0, div_b};
    assign rem_next  = take ? diff[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
    assign quo_next  = {quo[DATA_WIDTH-2:0], take};

`ifdef DIV_FASTPATH_EN
    localparam logic [DATA_WIDTH-1:0] MIN_INT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic                  div_zero;
    logic                  ovf;
    logic                  fast;
    logic [DATA_WIDTH-1:0] fast_quo;
    logic [DATA_WIDTH-1:0] fast_rem;

    assign div_zero = (divisor == '0);
    assign ovf      = is_signed_op(div_op) && (dividend == MIN_INT) && (divisor == '1);
    assign fast     = div_zero || ovf || (abs_a < abs_b);
    assign fast_quo = div_zero ? '1 : (ovf ? MIN_INT : '0);
    assign fast_rem = ovf ? '0 : dividend;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= DIV_OP_DIV;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            rem        <= '0;
            quo        <= '0;
            div_b      <= '0;
            cnt        <= '0;
            valid_q    <= 1'b0;
            div_result <= '0;
        end else begin
            valid_q <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (div_start) begin
                            op_q  <= div_op;
                            q_neg <= (a_neg ^ b_neg) & (divisor != '0);
                            r_neg <= a_neg;
                            rem   <= '0;
                            quo   <= abs_a;
                            div_b <= abs_b;
                            cnt   <= '0;
`ifdef DIV_FASTPATH_EN
                            if (fast) begin
                                div_result <= is_rem_op(div_op) ? fast_rem : fast_quo;
                                valid_q    <= 1'b1;
                                state      <= DONE;
                            end else begin
                                state <= CALC;
                            end
`else
                            state <= CALC;
`endif
                        end
                    end
                    CALC: begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST_STEP) state <= FIN;
                    end
                    FIN: begin
                        div_result <= is_rem_op(op_q) ? rem_fixed : quo_fixed;
                        valid_q    <= 1'b1;
                        state      <= DONE;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A flush arriving in the DONE cycle must still cancel the writeback.
    assign div_valid = valid_q & ~flush;
    assign div_busy  = (state != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: table of directed ops plus retrigger, flush and reset sequences.
// Fast-path latency expectations follow DIV_FASTPATH_EN when it is defined.
module tb_div_unit;

    localparam int W = 32;
`ifdef DIV_FASTPATH_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         div_start = 1'b0;
    logic [1:0]   div_op = 2'b00;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         flush = 1'b0;
    logic         div_busy;
    logic         div_valid;
    logic [W-1:0] div_result;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    div_unit #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_start  (div_start),
        .div_op     (div_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .flush      (flush),
        .div_busy   (div_busy),
        .div_valid  (div_valid),
        .div_result (div_result)
    );

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expected;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    task automatic check_output(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic int exp_latency(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit           sgn;
        logic [W-1:0] ma;
        logic [W-1:0] mb;
        bit           fast;
        sgn  = !op[0];
        ma   = (sgn && a[W-1]) ? (~a + 32'd1) : a;
        mb   = (sgn && b[W-1]) ? (~b + 32'd1) : b;
        fast = (b == '0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (ma < mb);
        return (FAST_EN && fast) ? 1 : W + 2;
    endfunction

    // Leaves time at #1 after the accepting edge, i.e. inside cycle 1.
    task automatic apply_stimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        div_op    = op;
        dividend  = a;
        divisor   = b;
        div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 1;
        while (cyc <= 60) begin
            if (div_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int  cyc;
        bit  seen;
        int  pulses;
        int  pulse_cyc;
        logic [W-1:0] held;

        vecs[0]  = '{"divu_100_7",    2'b01, 32'd100,        32'd7,          32'd14};
        vecs[1]  = '{"remu_100_7",    2'b11, 32'd100,        32'd7,          32'd2};
        vecs[2]  = '{"div_m7_2",      2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[3]  = '{"rem_m7_2",      2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[4]  = '{"rem_7_m2",      2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1};
        vecs[5]  = '{"div_7_m2",      2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
        vecs[6]  = '{"div_5_0",       2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[7]  = '{"rem_5_0",       2'b10, 32'd5,          32'd0,          32'd5};
        vecs[8]  = '{"div_ovf",       2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[9]  = '{"rem_ovf",       2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[10] = '{"divu_max_1",    2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
        vecs[11] = '{"divu_max_16",   2'b01, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF};
        vecs[12] = '{"remu_max_16",   2'b11, 32'hFFFF_FFFF,  32'd16,         32'd15};
        vecs[13] = '{"div_m8_m3",     2'b00, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2};
        vecs[14] = '{"rem_m8_m3",     2'b10, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'hFFFF_FFFE};
        vecs[15] = '{"divu_3_10",     2'b01, 32'd3,          32'd10,         32'd0};
        vecs[16] = '{"remu_neg_big",  2'b11, 32'hFFFF_FFF9,  32'd2,          32'd1};

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy",   {31'd0, div_busy},  32'd0);
        check_output("reset_valid",  {31'd0, div_valid}, 32'd0);
        check_output("reset_result", div_result,         32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_valid(cyc, seen);
            check_output({vecs[i].name, "_seen"}, {31'd0, seen}, 32'd1);
            check_output({vecs[i].name, "_latency"}, 32'(cyc), 32'(exp_latency(vecs[i].op, vecs[i].a, vecs[i].b)));
            check_output({vecs[i].name, "_result"}, div_result, vecs[i].expected);
        end

        // Second start during an op must be ignored: one valid, first op's result.
        apply_stimulus(2'b01, 32'd9, 32'd3);
        pulses    = 0;
        pulse_cyc = 0;
        for (int c = 1; c <= 45; c++) begin
            if (div_valid) begin
                pulses++;
                pulse_cyc = c;
            end
            if (c == 5) begin
                div_op    = 2'b01;
                dividend  = 32'd8;
                divisor   = 32'd2;
                div_start = 1'b1;
            end else begin
                div_start = 1'b0;
            end
            if (c == 34) held = div_result;
            @(posedge clk);
            #1;
        end
        check_output("retrigger_pulses", 32'(pulses),    32'd1);
        check_output("retrigger_cycle",  32'(pulse_cyc), 32'd34);
        check_output("retrigger_result", held,           32'd3);
        check_output("retrigger_held",   div_result,     32'd3);

        // Flush at cycle 10 aborts without a valid.
        apply_stimulus(2'b01, 32'd100, 32'd7);
        pulses = 0;
        for (int c = 1; c <= 45; c++) begin
            if (div_valid) pulses++;
            flush = (c == 10);
            @(posedge clk);
            #1;
            if (c == 10) check_output("flush_busy_drop", {31'd0, div_busy}, 32'd0);
        end
        flush = 1'b0;
        check_output("flush_no_valid", 32'(pulses), 32'd0);
        check_output("flush_result_held", div_result, 32'd3);

        // Asynchronous reset mid-op clears everything, and the op never completes.
        apply_stimulus(2'b01, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_busy",   {31'd0, div_busy},  32'd0);
        check_output("rst_mid_valid",  {31'd0, div_valid}, 32'd0);
        check_output("rst_mid_result", div_result,         32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 45; c++) begin
            if (div_valid) pulses++;
            @(posedge clk);
            #1;
        end
        check_output("rst_mid_no_valid", 32'(pulses), 32'd0);

        // Flush in the DONE cycle gates the valid pulse.
        apply_stimulus(2'b01, 32'd50, 32'd5);
        for (int c = 1; c < 34; c++) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        #1;
        check_output("flush_done_valid", {31'd0, div_valid}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;

        // Start together with flush in IDLE is dropped.
        @(posedge clk);
        #1;
        div_op    = 2'b01;
        dividend  = 32'd50;
        divisor   = 32'd5;
        div_start = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        flush     = 1'b0;
        check_output("flush_start_dropped", {31'd0, div_busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end

endmodule
